// File: rtl/led_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : led_reg_bank
// Description : Bank of WIDTH registered status bits, each driving an LED.
//               Every channel has a load-enabled data register and an
//               optional pulse stretcher, so that short events remain visible.
//               All stretchers share one prescaled timebase tick.
//
//               Optional feature macro: LED_BLINK_EN
//                 Adds blink_i and a global phase flop that toggles on every
//                 tick. Blinking channels are gated by the phase.
//
// Ports       : clk_i          clock, rising edge
//               rst_i          asynchronous reset, active-high
//               en_i           load enable for the data register
//               d_i            status data (WIDTH)
//               stretch_i      per-channel mode, 0 = level, 1 = stretch
//               stretch_len_i  stretch length in ticks (STRETCH_W)
//               blink_i        per-channel blink enable (LED_BLINK_EN only)
//               q_o            registered status (WIDTH)
//               led_o          LED drive, 1 = LED on (WIDTH)
//               tick_o         timebase tick strobe
//
// Revision    : 1.0 - initial release
// ============================================================================
module led_reg_bank #(
    parameter int WIDTH     = 8,
    parameter int STRETCH_W = 4,
    parameter int PRESCALE  = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [WIDTH-1:0]     d_i,
    input  logic [WIDTH-1:0]     stretch_i,
    input  logic [STRETCH_W-1:0] stretch_len_i,
`ifdef LED_BLINK_EN
    input  logic [WIDTH-1:0]     blink_i,
`endif
    output logic [WIDTH-1:0]     q_o,
    output logic [WIDTH-1:0]     led_o,
    output logic                 tick_o
);

    localparam int                 c_PRE_W   = $clog2(PRESCALE);
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(PRESCALE - 1);

    logic [c_PRE_W-1:0] r_pre;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_q_d;
    logic [WIDTH-1:0]   w_rise;
    logic [WIDTH-1:0]   w_base;
    logic               w_tick;

    // ------------------------------------------------------------------
    // Shared timebase: tick is a decode of the terminal count, so it is
    // one cycle wide and first appears PRESCALE-1 edges after reset.
    // ------------------------------------------------------------------
    assign w_tick = (r_pre == c_PRE_MAX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_PRE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Data register and its one-cycle delayed copy for edge detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_q   <= '0;
            r_q_d <= '0;
        end else begin
            if (en_i) begin
                r_q <= d_i;
            end
            r_q_d <= r_q;
        end
    end

    // High in the first cycle a channel's registered bit reads 1
    assign w_rise = r_q & ~r_q_d;

    // ------------------------------------------------------------------
    // Per-channel stretch counters
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic [STRETCH_W-1:0] r_cnt;

            // Priority: mode off clears, a rise (re)loads and wins over a
            // coincident tick, otherwise a tick decrements down to zero.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_cnt <= '0;
                end else if (!stretch_i[gi]) begin
                    r_cnt <= '0;
                end else if (w_rise[gi]) begin
                    r_cnt <= stretch_len_i;
                end else if (w_tick && (r_cnt != '0)) begin
                    r_cnt <= r_cnt - STRETCH_W'(1);
                end
            end

            // The counter is held at zero in level mode, so OR-ing it in
            // unconditionally keeps led a pure decode of registers; clearing
            // stretch_i removes the extension one cycle later.
            assign w_base[gi] = r_q[gi] | (r_cnt != '0);
        end
    endgenerate

    // ------------------------------------------------------------------
    // LED drive
    // ------------------------------------------------------------------
`ifdef LED_BLINK_EN
    logic r_phase;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_phase <= 1'b0;
        end else if (w_tick) begin
            r_phase <= ~r_phase;
        end
    end

    // Blinking channels show base only while the phase is high
    assign led_o = w_base & (~blink_i | {WIDTH{r_phase}});
`else
    assign led_o = w_base;
`endif

    assign q_o    = r_q;
    assign tick_o = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_reg_bank
// Description : Self-checking bench for led_reg_bank with WIDTH=8,
//               STRETCH_W=4, PRESCALE=4. A cycle model predicts the outputs
//               when stimulus is driven and queues them; they are popped and
//               compared after the clock edge. Directed checks cover reset,
//               tick spacing, stretch duration, mid-stretch mode/reset and
//               blink phase (LED_BLINK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_reg_bank;

    localparam int c_W  = 8;
    localparam int c_SW = 4;
    localparam int c_PS = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [c_W-1:0]  d;
    logic [c_W-1:0]  stretch;
    logic [c_SW-1:0] slen;
    logic [c_W-1:0]  blink;
    logic [c_W-1:0]  q;
    logic [c_W-1:0]  led;
    logic            tick;

    always #5 clk = ~clk;

    led_reg_bank #(
        .WIDTH    (c_W),
        .STRETCH_W(c_SW),
        .PRESCALE (c_PS)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .d_i          (d),
        .stretch_i    (stretch),
        .stretch_len_i(slen),
`ifdef LED_BLINK_EN
        .blink_i      (blink),
`endif
        .q_o          (q),
        .led_o        (led),
        .tick_o       (tick)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [c_W-1:0] q;
        logic [c_W-1:0] led;
        logic           tick;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    int              m_pre;
    logic [c_W-1:0]  m_q;
    logic [c_W-1:0]  m_qd;
    logic [c_SW-1:0] m_cnt [c_W];
    logic            m_phase;

    function automatic logic [c_W-1:0] m_led();
        logic [c_W-1:0] b;
        for (int i = 0; i < c_W; i++) b[i] = m_q[i] | (m_cnt[i] != 0);
`ifdef LED_BLINK_EN
        b = b & (~blink | {c_W{m_phase}});
`endif
        return b;
    endfunction

    task automatic m_reset();
        m_pre   = 0;
        m_q     = '0;
        m_qd    = '0;
        m_phase = 1'b0;
        for (int i = 0; i < c_W; i++) m_cnt[i] = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: predict, queue, clock, pop and compare
    task automatic step(input string tag);
        exp_t           e;
        logic [c_W-1:0] rise;
        logic           tk;
        tk   = (m_pre == c_PS - 1);
        rise = m_q & ~m_qd;
        for (int i = 0; i < c_W; i++) begin
            if (!stretch[i])                  m_cnt[i] = '0;
            else if (rise[i])                 m_cnt[i] = slen;
            else if (tk && (m_cnt[i] != 0))   m_cnt[i] = 4'(m_cnt[i] - 1);
        end
        m_qd = m_q;
        if (en) m_q = d;
        m_pre = tk ? 0 : m_pre + 1;
        if (tk) m_phase = ~m_phase;
        e.q    = m_q;
        e.led  = m_led();
        e.tick = (m_pre == c_PS - 1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".q"},    32'(q),    32'(e.q));
        check({tag, ".led"},  32'(led),  32'(e.led));
        check({tag, ".tick"}, 32'(tick), 32'(e.tick));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c;
        logic [c_W-1:0] exp_b;

        // ---------------- 1. reset ----------------
        rst = 1'b1; en = 1'b1; d = 8'hFF; stretch = '0; slen = '0; blink = '0;
        m_reset();
        #3;
        check("rst.q",    32'(q),    0);
        check("rst.led",  32'(led),  0);
        check("rst.tick", 32'(tick), 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_held.q",   32'(q),   0);
        check("rst_held.led", 32'(led), 0);
        rst = 1'b0; en = 1'b0; d = '0;

        n = 0;
        for (int k = 0; k < 10; k++) begin
            step("tick_first");
            n++;
            if (tick) break;
        end
        check("tick_first_cycle", 32'(n), 3);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            step("tick_period");
            n++;
            if (tick) break;
        end
        check("tick_period", 32'(n), 4);

        // ---------------- 2. level load ----------------
        stretch = '0; d = 8'hA5; en = 1'b1;
        step("load");
        check("load_q",   32'(q),   32'h A5);
        check("load_led", 32'(led), 32'h A5);
        d = 8'h00; en = 1'b0;
        step("hold");
        step("hold");
        check("hold_q", 32'(q), 32'h A5);
        en = 1'b1;
        step("clear");
        en = 1'b0;
        step("idle");
        step("idle");

        // ---------------- 3. stretch one-cycle pulse ----------------
        stretch = 8'h01; slen = 4'd3; d = 8'h01; en = 1'b1;
        step("pulse_hi");
        d = 8'h00;
        step("pulse_lo");
        en = 1'b0;
        check("pulse_q0_fell", 32'(q[0]), 0);
        c = 0;
        for (int k = 0; k < 30; k++) begin
            if (!led[0]) break;
            c++;
            step("stretch");
        end
        check("stretch_dur_in_9_12", 32'((c >= 9) && (c <= 12)), 1);
        check("stretch_other_ch", 32'(led[7:1]), 0);
        step("stretch_done");

        // ---------------- 4. retrigger / tick collision ----------------
        for (int k = 0; k < 8; k++) begin
            if (m_pre == c_PS - 2) break;
            step("align");
        end
        check("align_pre", 32'(m_pre), c_PS - 2);
        d = 8'h01; en = 1'b1;
        step("coll_rise");
        check("coll_tick", 32'(tick), 1);
        d = 8'h00;
        step("coll_fall");
        en = 1'b0;
        repeat (5) step("coll_count");
        d = 8'h01; en = 1'b1;
        step("retrig_rise");
        d = 8'h00;
        step("retrig_fall");
        en = 1'b0;
        check("retrig_led0", 32'(led[0]), 1);
        repeat (14) step("retrig_count");

        // ---------------- 5. mode / reset mid-stretch ----------------
        d = 8'h01; en = 1'b1;
        step("mode_rise");
        d = 8'h00;
        step("mode_fall");
        en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (m_cnt[0] == 2) break;
            step("mode_wait");
        end
        check("mode_cnt_reached", 32'(m_cnt[0]), 2);
        stretch = 8'h00;
        step("mode_clear");
        check("mode_clear_led0", 32'(led[0]), 0);
        check("mode_clear_q0",   32'(q[0]),   0);

        stretch = 8'h01; d = 8'h01; en = 1'b1;
        step("rst_rise");
        d = 8'h00;
        step("rst_fall");
        en = 1'b0;
        check("rst_mid_led0_on", 32'(led[0]), 1);
        rst = 1'b1;
        m_reset();
        #1;
        check("rst_async.led",  32'(led),  0);
        check("rst_async.q",    32'(q),    0);
        check("rst_async.tick", 32'(tick), 0);

        // ---------------- 6. blink ----------------
        stretch = 8'h00; blink = 8'h80; d = 8'h80; en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step("blink");
`ifdef LED_BLINK_EN
            exp_b = ((k / 4) % 2 == 1) ? 8'h80 : 8'h00;
`else
            exp_b = 8'h80;
`endif
            check($sformatf("blink_led7_k%0d", k), 32'(led[7]), 32'(exp_b[7]));
        end
        en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
